// File: rtl/imit_param_pkg.sv
// ----------------------------------------------------------------------------
// imit_param_pkg
// Shared types and helpers for the imitator parameter loader.
//   state_e      : loader FSM states (IDLE waits for words, ARMED waits for epoch)
//   commit_addr  : address of the commit command (all-ones in the addr field)
//   addr_lsb     : bit position of the addr field inside sync_data
//   data_msb     : top bit of the data field inside sync_data
//   CMT_IMM      : data bit of a commit word selecting an immediate copy
// ----------------------------------------------------------------------------
package imit_param_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } state_e;

    localparam int CMT_IMM = 0;

    function automatic int commit_addr(input int addr_w);
        return (1 << addr_w) - 1;
    endfunction

    // sync_data = {addr, data}: addr sits directly above the data field.
    function automatic int addr_lsb(input int data_w);
        return data_w;
    endfunction

    function automatic int data_msb(input int data_w);
        return data_w - 1;
    endfunction

endpackage

// File: rtl/imit_param_loader.sv
// ----------------------------------------------------------------------------
// imit_param_loader
// Destination-clock consumer of the CDC word channel. Words land in a shadow
// bank; a commit word moves dirty shadow registers into the active bank either
// at once or at the next imitator code epoch, so parameter sets change
// atomically on a code boundary.
//
// Ports
//   clk          in   destination clock
//   reset_n      in   asynchronous active-low reset
//   ready        in   one-cycle word strobe, sync_data valid in that cycle
//   sync_data    in   {addr, data}, addr in the MSBs
//   epoch        in   one-cycle code-epoch strobe
//   active_regs  out  active bank, reg i at [i*DATA_W +: DATA_W]
//   update       out  one-cycle pulse the cycle after any active-bank copy
//   armed        out  high while waiting for an epoch (FSM state)
//   dirty        out  per-register shadow-written-since-last-copy flags
//   addr_err     out  one-cycle pulse the cycle after an invalid address
//   timeout      out  sticky, set when an armed wait times out
// ----------------------------------------------------------------------------
module imit_param_loader
    import imit_param_pkg::*;
#(
    parameter int N_REGS    = 8,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 4,
    parameter int TO_CYCLES = 0
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       ready,
    input  logic [ADDR_W+DATA_W-1:0]   sync_data,
    input  logic                       epoch,
    output logic [N_REGS*DATA_W-1:0]   active_regs,
    output logic                       update,
    output logic                       armed,
    output logic [N_REGS-1:0]          dirty,
    output logic                       addr_err,
    output logic                       timeout
);

    localparam int ADDR_LSB = addr_lsb(DATA_W);
    localparam int DATA_MSB = data_msb(DATA_W);
    localparam logic [ADDR_W-1:0] COMMIT   = ADDR_W'(commit_addr(ADDR_W));
    localparam logic [ADDR_W-1:0] N_REGS_A = ADDR_W'(N_REGS);

    // Word decode
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_en;
    logic              cmd_any;
    logic              cmd_imm;
    logic              cmd_epc;
    logic              bad_addr;

    assign wr_addr  = sync_data[ADDR_LSB +: ADDR_W];
    assign wr_data  = sync_data[DATA_MSB:0];
    assign wr_en    = ready && (wr_addr < N_REGS_A);
    assign cmd_any  = ready && (wr_addr == COMMIT);
    assign cmd_imm  = cmd_any && wr_data[CMT_IMM];
    assign cmd_epc  = cmd_any && !wr_data[CMT_IMM];
    assign bad_addr = ready && !(wr_addr < N_REGS_A) && (wr_addr != COMMIT);

    // FSM
    state_e state_q, state_d;
    logic   copy_en;
    logic   to_hit;     // armed wait has reached its last allowed cycle
    logic   to_fire;    // forced copy because no epoch arrived in time

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cmd_epc) state_d = ARMED;
            ARMED:   if (copy_en) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        copy_en = 1'b0;
        to_fire = 1'b0;
        case (state_q)
            IDLE: copy_en = cmd_imm;
            ARMED: begin
                // An epoch or immediate commit on the timeout edge wins: it is
                // a normal copy and the sticky timeout flag is not raised.
                to_fire = to_hit && !epoch && !cmd_imm;
                copy_en = epoch || cmd_imm || to_fire;
            end
            default: ;
        endcase
    end

    // Armed-wait counter, only present when a timeout is configured
    if (TO_CYCLES > 0) begin : g_to
        localparam int CNT_W = $clog2(TO_CYCLES + 1);
        localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TO_CYCLES - 1);
        localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TO_CYCLES);

        logic [CNT_W-1:0] cnt_q, cnt_d;

        // Held at zero outside ARMED, so arming always starts from zero and
        // a repeated epoch commit while armed does not restart the count.
        always_comb begin
            cnt_d = '0;
            if (state_q == ARMED)
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) cnt_q <= '0;
            else          cnt_q <= cnt_d;
        end

        assign to_hit = (state_q == ARMED) && (cnt_q == CNT_LAST);
    end else begin : g_no_to
        assign to_hit = 1'b0;
    end

    // Status flags
    logic update_q, addr_err_q, timeout_q, timeout_d;

    always_comb begin
        timeout_d = timeout_q;
        if (to_fire)      timeout_d = 1'b1;
        else if (cmd_any) timeout_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            update_q   <= 1'b0;
            addr_err_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            update_q   <= copy_en;
            addr_err_q <= bad_addr;
            timeout_q  <= timeout_d;
        end
    end

    assign update   = update_q;
    assign addr_err = addr_err_q;
    assign timeout  = timeout_q;
    assign armed    = (state_q == ARMED);

    // Register bank: one shadow/active/dirty slice per register
    for (genvar i = 0; i < N_REGS; i++) begin : g_reg
        logic [DATA_W-1:0] shadow_q, shadow_d;
        logic [DATA_W-1:0] active_q, active_d;
        logic              dirty_q, dirty_d;
        logic              wr_hit;

        assign wr_hit = wr_en && (wr_addr == ADDR_W'(i));

        // The copy reads the pre-edge shadow; a write on the same edge sets
        // dirty again so it is picked up by the next commit.
        always_comb begin
            shadow_d = shadow_q;
            active_d = active_q;
            dirty_d  = dirty_q;
            if (copy_en && dirty_q) begin
                active_d = shadow_q;
                dirty_d  = 1'b0;
            end
            if (wr_hit) begin
                shadow_d = wr_data;
                dirty_d  = 1'b1;
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                shadow_q <= '0;
                active_q <= '0;
                dirty_q  <= 1'b0;
            end else begin
                shadow_q <= shadow_d;
                active_q <= active_d;
                dirty_q  <= dirty_d;
            end
        end

        assign active_regs[i*DATA_W +: DATA_W] = active_q;
        assign dirty[i]                        = dirty_q;
    end

endmodule

// File: tb/tb_imit_param_loader.sv
// ----------------------------------------------------------------------------
// tb_imit_param_loader
// Randomised and directed stimulus for imit_param_loader, compared every cycle
// against a behavioural model of the shadow/active banks.
// ----------------------------------------------------------------------------
module tb_imit_param_loader;

    localparam int N_REGS    = 8;
    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 4;
    localparam int TO_CYCLES = 16;
    localparam int BANK_W    = N_REGS * DATA_W;

    // ------------------------------------------------------------------ clock/reset
    logic                     clk = 1'b0;
    logic                     reset_n;
    logic                     ready;
    logic [ADDR_W+DATA_W-1:0] sync_data;
    logic                     epoch;
    logic [BANK_W-1:0]        active_regs;
    logic                     update;
    logic                     armed;
    logic [N_REGS-1:0]        dirty;
    logic                     addr_err;
    logic                     timeout;

    always #5 clk = ~clk;

    imit_param_loader #(
        .N_REGS   (N_REGS),
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .TO_CYCLES(TO_CYCLES)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ready      (ready),
        .sync_data  (sync_data),
        .epoch      (epoch),
        .active_regs(active_regs),
        .update     (update),
        .armed      (armed),
        .dirty      (dirty),
        .addr_err   (addr_err),
        .timeout    (timeout)
    );

    // ------------------------------------------------------------------ scoreboard
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [BANK_W-1:0] got, input logic [BANK_W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------ reference model
    // Plain arrays and flags describing what the loader has promised so far.
    logic [DATA_W-1:0] m_shadow [N_REGS];
    logic [DATA_W-1:0] m_active [N_REGS];
    bit                m_dirty  [N_REGS];
    bit                m_armed;
    int                m_wait;        // edges spent armed without a copy
    bit                m_timeout;
    bit                m_update;
    bit                m_addr_err;

    task automatic model_reset();
        for (int i = 0; i < N_REGS; i++) begin
            m_shadow[i] = '0;
            m_active[i] = '0;
            m_dirty[i]  = 1'b0;
        end
        m_armed    = 1'b0;
        m_wait     = 0;
        m_timeout  = 1'b0;
        m_update   = 1'b0;
        m_addr_err = 1'b0;
    endtask

    task automatic model_edge(input bit rdy, input int a, input logic [DATA_W-1:0] d, input bit ep);
        bit is_cmt, imm, do_copy, timed_out;
        is_cmt    = rdy && (a == (1 << ADDR_W) - 1);
        imm       = is_cmt && d[0];
        do_copy   = 1'b0;
        timed_out = 1'b0;
        if (!m_armed) begin
            if (imm) do_copy = 1'b1;
            else if (is_cmt) begin
                m_armed = 1'b1;
                m_wait  = 0;
            end
        end else begin
            if (ep || imm) begin
                do_copy = 1'b1;
                m_armed = 1'b0;
            end else if (m_wait == TO_CYCLES - 1) begin
                do_copy   = 1'b1;
                timed_out = 1'b1;
                m_armed   = 1'b0;
            end else begin
                m_wait++;
            end
        end
        if (timed_out)   m_timeout = 1'b1;
        else if (is_cmt) m_timeout = 1'b0;
        // Copy first: it sees the shadow bank as it was before this edge.
        if (do_copy)
            for (int i = 0; i < N_REGS; i++)
                if (m_dirty[i]) begin
                    m_active[i] = m_shadow[i];
                    m_dirty[i]  = 1'b0;
                end
        if (rdy && a < N_REGS) begin
            m_shadow[a] = d;
            m_dirty[a]  = 1'b1;
        end
        m_update   = do_copy;
        m_addr_err = rdy && (a >= N_REGS) && !is_cmt;
    endtask

    function automatic logic [BANK_W-1:0] model_bank();
        logic [BANK_W-1:0] v;
        for (int i = 0; i < N_REGS; i++) v[i*DATA_W +: DATA_W] = m_active[i];
        return v;
    endfunction

    function automatic logic [N_REGS-1:0] model_dirty();
        logic [N_REGS-1:0] v;
        for (int i = 0; i < N_REGS; i++) v[i] = m_dirty[i];
        return v;
    endfunction

    task automatic check_all(input string ph);
        chk({ph, ".active"},   active_regs,                   model_bank());
        chk({ph, ".dirty"},    BANK_W'(dirty),                BANK_W'(model_dirty()));
        chk({ph, ".update"},   BANK_W'(update),               BANK_W'(m_update));
        chk({ph, ".armed"},    BANK_W'(armed),                BANK_W'(m_armed));
        chk({ph, ".addr_err"}, BANK_W'(addr_err),             BANK_W'(m_addr_err));
        chk({ph, ".timeout"},  BANK_W'(timeout),              BANK_W'(m_timeout));
    endtask

    // ------------------------------------------------------------------ driver tasks
    string phase = "rst";

    task automatic step(input bit rdy, input int a, input logic [DATA_W-1:0] d, input bit ep);
        ready     = rdy;
        sync_data = {ADDR_W'(a), d};
        epoch     = ep;
        @(posedge clk);
        model_edge(rdy, a, d, ep);
        #1;
        check_all(phase);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 0, '0, 1'b0);
    endtask

    task automatic async_reset();
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all({phase, ".async"});
        #2;
        reset_n = 1'b1;
    endtask

    // ------------------------------------------------------------------ sequence
    initial begin
        reset_n   = 1'b0;
        ready     = 1'b0;
        sync_data = '0;
        epoch     = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all("rst");
        reset_n = 1'b1;

        // Immediate commit of a single register
        phase = "t1";
        step(1'b1, 2, 32'hDEADBEEF, 1'b0);
        step(1'b1, 15, 32'h1, 1'b0);
        chk("t1.reg2", BANK_W'(active_regs[2*DATA_W +: DATA_W]), BANK_W'(32'hDEADBEEF));
        chk("t1.update", BANK_W'(update), BANK_W'(1'b1));
        idle(2);

        // Epoch commit, epoch ten cycles later
        phase = "t2";
        step(1'b1, 0, 32'd5, 1'b0);
        step(1'b1, 15, 32'h0, 1'b0);
        idle(9);
        chk("t2.reg0_before", BANK_W'(active_regs[0 +: DATA_W]), BANK_W'(0));
        step(1'b0, 0, '0, 1'b1);
        chk("t2.reg0_after", BANK_W'(active_regs[0 +: DATA_W]), BANK_W'(5));
        idle(2);

        // Write racing the epoch copy
        phase = "t3";
        step(1'b1, 1, 32'd7, 1'b0);
        step(1'b1, 15, 32'h0, 1'b0);
        idle(3);
        step(1'b1, 1, 32'd9, 1'b1);
        chk("t3.reg1_old", BANK_W'(active_regs[1*DATA_W +: DATA_W]), BANK_W'(7));
        chk("t3.dirty1", BANK_W'(dirty[1]), BANK_W'(1'b1));
        step(1'b1, 15, 32'h1, 1'b0);
        chk("t3.reg1_new", BANK_W'(active_regs[1*DATA_W +: DATA_W]), BANK_W'(9));
        idle(1);

        // Invalid address and stray epoch in IDLE
        phase = "t4";
        step(1'b1, 10, 32'h12345678, 1'b0);
        chk("t4.addr_err", BANK_W'(addr_err), BANK_W'(1'b1));
        step(1'b0, 0, '0, 1'b1);
        idle(1);
        chk("t4.no_update", BANK_W'(update), BANK_W'(1'b0));

        // Timeout after sixteen armed cycles
        phase = "t5";
        step(1'b1, 3, 32'h33, 1'b0);
        step(1'b1, 15, 32'h0, 1'b0);
        idle(TO_CYCLES + 4);
        chk("t5.timeout", BANK_W'(timeout), BANK_W'(1'b1));
        chk("t5.reg3", BANK_W'(active_regs[3*DATA_W +: DATA_W]), BANK_W'(32'h33));
        step(1'b1, 15, 32'h1, 1'b0);
        chk("t5.cleared", BANK_W'(timeout), BANK_W'(1'b0));
        idle(1);

        // Reset while armed with dirty registers
        phase = "t6";
        step(1'b1, 4, 32'h44, 1'b0);
        step(1'b1, 15, 32'h0, 1'b0);
        idle(2);
        async_reset();
        step(1'b0, 0, '0, 1'b1);
        idle(1);
        chk("t6.no_update", BANK_W'(update), BANK_W'(1'b0));

        // Random traffic
        phase = "rnd";
        for (int n = 0; n < 3000; n++) begin
            int sel, a;
            logic [DATA_W-1:0] d;
            bit ep;
            sel = $urandom_range(0, 9);
            d   = $urandom();
            ep  = ($urandom_range(0, 29) == 0);
            if (sel <= 3)      step(1'b0, 0, d, ep);
            else if (sel <= 7) step(1'b1, $urandom_range(0, N_REGS - 1), d, ep);
            else if (sel == 8) step(1'b1, 15, d, ep);
            else begin
                a = $urandom_range(N_REGS, 14);
                step(1'b1, a, d, ep);
            end
            if ($urandom_range(0, 999) == 0) async_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
